// File: rtl/debugger_apb_initiator_if.sv
// Host command/response port and APB requester bus of the debugger APB initiator.
// master: the initiator side; slave: host plus APB responder side.
interface debugger_apb_initiator_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/debugger_apb_initiator.sv
// APB initiator: one host command becomes one SETUP+ACCESS transfer, with wait states,
// an optional wait-state timeout, and a held response until the host consumes it.
module debugger_apb_initiator #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    debugger_apb_initiator_if.master bus_io
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.cmd_valid) begin
                    pwrite_d = bus_io.cmd_write;
                    paddr_d  = bus_io.cmd_addr;
                    pwdata_d = bus_io.cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout landing on the same cycle
                if (bus_io.PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus_io.PRDATA;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus_io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.cmd_ready = (state_q == IDLE);
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_error = rsp_error_q;
    assign bus_io.PSEL      = psel_q;
    assign bus_io.PENABLE   = penable_q;
    assign bus_io.PWRITE    = pwrite_q;
    assign bus_io.PADDR     = paddr_q;
    assign bus_io.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_debugger_apb_initiator.sv
// Bench for debugger_apb_initiator: directed corner transfers plus random transfers
// checked against a transaction-level model of latency, wait states, timeout and response.
module tb_debugger_apb_initiator;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    debugger_apb_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    debugger_apb_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge in IDLE; returns on a negedge in IDLE after the response is consumed.
    task automatic run_txn(input logic w, input logic [4:0] a, input logic [7:0] d,
                           input int waits, input logic [7:0] prd, input int hold, input bit pend);
        int  acc_cycles;
        int  lat;
        bit  err;
        logic [7:0] rd;
        int  c;
        int  acc;
        int  psel_n;
        int  pen_n;
        bit  done;

        // transaction-level expectations
        err        = (waits >= int'(TIMEOUT));
        acc_cycles = err ? int'(TIMEOUT) : waits + 1;
        lat        = 2 + acc_cycles;
        rd         = (err || w) ? 8'h00 : prd;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.rsp_ready = 1'b0;
        check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 5'($urandom);
        bus.cmd_wdata = 8'($urandom);

        c = 0; acc = 0; psel_n = 0; pen_n = 0; done = 1'b0;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
            if (bus.rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bus.PSEL) begin
                    psel_n++;
                    check_eq("apb_fields", {18'd0, bus.PWRITE, bus.PADDR, bus.PWDATA}, {18'd0, w, a, d});
                end
                if (bus.PENABLE) begin
                    pen_n++;
                    bus.PREADY = (acc == waits);
                    bus.PRDATA = bus.PREADY ? prd : 8'($urandom);
                    acc++;
                end else begin
                    bus.PREADY = 1'($urandom);
                    bus.PRDATA = 8'($urandom);
                end
            end
        end
        check_eq("rsp_seen", 32'(done), 32'd1);
        check_eq("rsp_latency", 32'(c), 32'(lat));
        check_eq("psel_cycles", 32'(psel_n), 32'(acc_cycles + 1));
        check_eq("penable_cycles", 32'(pen_n), 32'(acc_cycles));
        check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd));
        check_eq("rsp_error", 32'(bus.rsp_error), 32'(err));
        check_eq("resp_bus_idle", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
        check_eq("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);

        if (pend) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = 5'($urandom);
            bus.cmd_wdata = 8'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            bus.PREADY = 1'($urandom);
            bus.PRDATA = 8'($urandom);
            @(negedge clk);
            check_eq("hold_rsp", {22'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata},
                     {22'd0, 1'b1, err, rd});
            check_eq("hold_bus", {29'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check_eq("idle_after_rsp", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        #12;
        check_eq("reset_outs", {14'd0, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
                 32'd0);
        check_eq("reset_rsp", {22'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, 32'd0);
        check_eq("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 5'h01, 8'hA5, 0, 8'h00, 0, 1'b0);
        run_txn(1'b0, 5'h08, 8'h00, 1, 8'h3C, 0, 1'b0);
        run_txn(1'b0, 5'h02, 8'h00, 40, 8'h99, 0, 1'b0);
        run_txn(1'b0, 5'h03, 8'h00, 0, 8'h55, 5, 1'b1);
        run_txn(1'b1, 5'h04, 8'h12, 0, 8'h00, 0, 1'b0);

        // reset in the middle of an ACCESS wait sequence
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 5'h09;
        bus.cmd_wdata = 8'h6E;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
        rst = 1'b1;
        #1;
        check_eq("rst_drop", {29'd0, bus.PSEL, bus.PENABLE, bus.rsp_valid}, 32'd0);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_idle", {29'd0, bus.rsp_valid, bus.PSEL, bus.cmd_ready}, 32'd1);
        run_txn(1'b1, 5'h05, 8'hC3, 0, 8'h00, 0, 1'b0);

        run_txn(1'b0, 5'h0A, 8'h00, int'(TIMEOUT) - 1, 8'h77, 0, 1'b0);
        run_txn(1'b0, 5'h0B, 8'h00, int'(TIMEOUT), 8'h44, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [4:0] a;
            int         wt;
            a  = 5'($urandom_range(0, 24));
            wt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 20))
                                              : int'($urandom_range(0, 3));
            if (a >= 5'h08 && wt == 0) wt = 1;
            run_txn(1'($urandom), a, 8'($urandom), wt, 8'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
